// File: rtl/bp_tlb_ptw_arbiter.sv
// Arbitrates ITLB/DTLB misses onto a single page-table walker, one walk in flight.
// Define BP_TLB_PTW_ARB_PERF_EN to add saturating grant/abort counters.
module bp_tlb_ptw_arbiter #(
  parameter int vtag_width_p  = 27,
  parameter int entry_width_p = 40
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     itlb_miss_v_i,
  input  logic [vtag_width_p-1:0]  itlb_miss_vtag_i,
  output logic                     itlb_miss_ready_o,
  input  logic                     dtlb_miss_v_i,
  input  logic [vtag_width_p-1:0]  dtlb_miss_vtag_i,
  output logic                     dtlb_miss_ready_o,
  output logic                     ptw_req_v_o,
  output logic [vtag_width_p-1:0]  ptw_req_vtag_o,
  input  logic                     ptw_req_ready_i,
  input  logic                     ptw_resp_v_i,
  input  logic                     ptw_resp_fault_i,
  input  logic [entry_width_p-1:0] ptw_resp_entry_i,
  output logic                     itlb_fill_v_o,
  output logic                     dtlb_fill_v_o,
  output logic [vtag_width_p-1:0]  fill_vtag_o,
  output logic [entry_width_p-1:0] fill_entry_o,
  output logic                     fault_v_o,
  output logic                     fault_src_o,
  input  logic                     flush_i,
  output logic                     busy_o
`ifdef BP_TLB_PTW_ARB_PERF_EN
  ,
  output logic [31:0]              itlb_grants_o,
  output logic [31:0]              dtlb_grants_o,
  output logic [31:0]              flush_aborts_o
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FILL, S_DRAIN} state_e;

  state_e                   state_r, state_n;
  logic                     last_grant_r;  // 0 = ITLB, 1 = DTLB
  logic                     owner_r;
  logic                     fault_r;
  logic [vtag_width_p-1:0]  vtag_r;
  logic [vtag_width_p-1:0]  fill_vtag_r;
  logic [entry_width_p-1:0] fill_entry_r;

  logic grant_itlb, grant_dtlb;
  logic req_v, itlb_fill_v, dtlb_fill_v, fault_v;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_n     = state_r;
    grant_itlb  = 1'b0;
    grant_dtlb  = 1'b0;
    req_v       = 1'b0;
    itlb_fill_v = 1'b0;
    dtlb_fill_v = 1'b0;
    fault_v     = 1'b0;
    case (state_r)
      S_IDLE: begin
        // Grants are also masked while reset is held so ready reads 0 in reset.
        if (!flush_i && reset_n_i) begin
          if (itlb_miss_v_i && (!dtlb_miss_v_i || last_grant_r)) grant_itlb = 1'b1;
          else if (dtlb_miss_v_i)                                grant_dtlb = 1'b1;
        end
        if (grant_itlb || grant_dtlb) state_n = S_REQ;
      end
      S_REQ: begin
        if (flush_i) state_n = S_IDLE;
        else begin
          req_v = 1'b1;
          if (ptw_req_ready_i) state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response coinciding with flush is consumed here, so nothing is left to drain.
        if (flush_i)           state_n = ptw_resp_v_i ? S_IDLE : S_DRAIN;
        else if (ptw_resp_v_i) state_n = S_FILL;
      end
      S_FILL: begin
        state_n = S_IDLE;
        if (!flush_i) begin
          if (fault_r)      fault_v     = 1'b1;
          else if (owner_r) dtlb_fill_v = 1'b1;
          else              itlb_fill_v = 1'b1;
        end
      end
      S_DRAIN: if (ptw_resp_v_i) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= S_IDLE;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      fault_r      <= 1'b0;
      vtag_r       <= '0;
      // NOTE: payload registers are reset too because they drive outputs directly.
      fill_vtag_r  <= '0;
      fill_entry_r <= '0;
    end else begin
      state_r <= state_n;
      if (grant_itlb || grant_dtlb) begin
        vtag_r       <= grant_dtlb ? dtlb_miss_vtag_i : itlb_miss_vtag_i;
        owner_r      <= grant_dtlb;
        last_grant_r <= grant_dtlb;
      end
      if (state_r == S_WAIT && ptw_resp_v_i && !flush_i) begin
        fill_vtag_r  <= vtag_r;
        fill_entry_r <= ptw_resp_entry_i;
        fault_r      <= ptw_resp_fault_i;
      end
    end
  end

  assign itlb_miss_ready_o = grant_itlb;
  assign dtlb_miss_ready_o = grant_dtlb;
  assign ptw_req_v_o       = req_v;
  assign ptw_req_vtag_o    = vtag_r;
  assign itlb_fill_v_o     = itlb_fill_v;
  assign dtlb_fill_v_o     = dtlb_fill_v;
  assign fill_vtag_o       = fill_vtag_r;
  assign fill_entry_o      = fill_entry_r;
  assign fault_v_o         = fault_v;
  assign fault_src_o       = fault_v & owner_r;
  assign busy_o            = (state_r != S_IDLE);

`ifdef BP_TLB_PTW_ARB_PERF_EN
  logic        abort;
  logic [31:0] itlb_cnt_r, dtlb_cnt_r, abort_cnt_r;

  assign abort = flush_i && ((state_r == S_REQ) || (state_r == S_WAIT && !ptw_resp_v_i));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      itlb_cnt_r  <= '0;
      dtlb_cnt_r  <= '0;
      abort_cnt_r <= '0;
    end else begin
      if (grant_itlb && itlb_cnt_r  != '1) itlb_cnt_r  <= itlb_cnt_r + 32'd1;
      if (grant_dtlb && dtlb_cnt_r  != '1) dtlb_cnt_r  <= dtlb_cnt_r + 32'd1;
      if (abort      && abort_cnt_r != '1) abort_cnt_r <= abort_cnt_r + 32'd1;
    end
  end

  assign itlb_grants_o  = itlb_cnt_r;
  assign dtlb_grants_o  = dtlb_cnt_r;
  assign flush_aborts_o = abort_cnt_r;
`endif

endmodule

// File: tb/tb_bp_tlb_ptw_arbiter.sv
// Self-checking bench for bp_tlb_ptw_arbiter: walk table, directed corner cases,
// and a randomized run against a transaction-level model.
module tb_bp_tlb_ptw_arbiter;

  localparam int VW = 27;
  localparam int EW = 40;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          itlb_miss_v = 1'b0, dtlb_miss_v = 1'b0;
  logic [VW-1:0] itlb_miss_vtag = '0, dtlb_miss_vtag = '0;
  logic          itlb_miss_ready, dtlb_miss_ready;
  logic          ptw_req_v;
  logic [VW-1:0] ptw_req_vtag;
  logic          ptw_req_ready = 1'b0;
  logic          ptw_resp_v = 1'b0, ptw_resp_fault = 1'b0;
  logic [EW-1:0] ptw_resp_entry = '0;
  logic          itlb_fill_v, dtlb_fill_v;
  logic [VW-1:0] fill_vtag;
  logic [EW-1:0] fill_entry;
  logic          fault_v, fault_src;
  logic          flush = 1'b0;
  logic          busy;
`ifdef BP_TLB_PTW_ARB_PERF_EN
  logic [31:0]   itlb_grants, dtlb_grants, flush_aborts;
`endif

  int checks = 0;
  int failures = 0;

  bp_tlb_ptw_arbiter #(.vtag_width_p(VW), .entry_width_p(EW)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .itlb_miss_v_i(itlb_miss_v), .itlb_miss_vtag_i(itlb_miss_vtag), .itlb_miss_ready_o(itlb_miss_ready),
    .dtlb_miss_v_i(dtlb_miss_v), .dtlb_miss_vtag_i(dtlb_miss_vtag), .dtlb_miss_ready_o(dtlb_miss_ready),
    .ptw_req_v_o(ptw_req_v), .ptw_req_vtag_o(ptw_req_vtag), .ptw_req_ready_i(ptw_req_ready),
    .ptw_resp_v_i(ptw_resp_v), .ptw_resp_fault_i(ptw_resp_fault), .ptw_resp_entry_i(ptw_resp_entry),
    .itlb_fill_v_o(itlb_fill_v), .dtlb_fill_v_o(dtlb_fill_v),
    .fill_vtag_o(fill_vtag), .fill_entry_o(fill_entry),
    .fault_v_o(fault_v), .fault_src_o(fault_src),
    .flush_i(flush), .busy_o(busy)
`ifdef BP_TLB_PTW_ARB_PERF_EN
    , .itlb_grants_o(itlb_grants), .dtlb_grants_o(dtlb_grants), .flush_aborts_o(flush_aborts)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {itlb_miss_ready, dtlb_miss_ready, ptw_req_v, ptw_req_vtag, itlb_fill_v, dtlb_fill_v,
            fill_vtag, fill_entry, fault_v, fault_src, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_itlb_fill"}, itlb_fill_v, 0);
    check({name, "_dtlb_fill"}, dtlb_fill_v, 0);
    check({name, "_fault"}, fault_v, 0);
  endtask

  task automatic clear_inputs();
    itlb_miss_v = 0; dtlb_miss_v = 0; ptw_req_ready = 0;
    ptw_resp_v = 0; ptw_resp_fault = 0; flush = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    tick();
  endtask

  typedef struct {
    logic          iv, dv;
    logic [VW-1:0] itag, dtag;
    logic          owner;   // 0 = ITLB, 1 = DTLB
    logic          fault;
    logic [EW-1:0] entry;
    int            delay;   // WAIT cycles before the response
  } walk_vec_t;

  walk_vec_t vecs[8];

  // Full walk from IDLE: grant, request, wait, response, strobe, back to IDLE.
  task automatic run_walk(input walk_vec_t v);
    logic [VW-1:0] etag;
    etag = v.owner ? v.dtag : v.itag;
    itlb_miss_v = v.iv; dtlb_miss_v = v.dv;
    itlb_miss_vtag = v.itag; dtlb_miss_vtag = v.dtag;
    mid();
    check("idle_busy", busy, 0);
    check("grant_itlb_ready", itlb_miss_ready, !v.owner);
    check("grant_dtlb_ready", dtlb_miss_ready, v.owner);
    tick();
    itlb_miss_v = 0; dtlb_miss_v = 0; ptw_req_ready = 1;
    mid();
    check("req_v", ptw_req_v, 1);
    check("req_vtag", ptw_req_vtag, etag);
    tick();
    ptw_req_ready = 0;
    for (int i = 0; i < v.delay; i++) begin
      mid();
      check("wait_req_v", ptw_req_v, 0);
      check_quiet("wait");
      tick();
    end
    ptw_resp_v = 1; ptw_resp_fault = v.fault; ptw_resp_entry = v.entry;
    mid();
    check_quiet("resp");
    tick();
    ptw_resp_v = 0;
    mid();
    check("fill_itlb_strobe", itlb_fill_v, !v.owner && !v.fault);
    check("fill_dtlb_strobe", dtlb_fill_v, v.owner && !v.fault);
    check("fault_strobe", fault_v, v.fault);
    check("fault_src", fault_src, v.fault && v.owner);
    check("fill_vtag", fill_vtag, etag);
    check("fill_entry", fill_entry, v.entry);
    tick();
    mid();
    check("post_fill_busy", busy, 0);
    check_quiet("post_fill");
    tick();
  endtask

  // Walk flushed in WAIT; response arrives 3 cycles after the flush and is drained.
  task automatic flush_wait_walk(input logic iv, input logic dv, input logic [VW-1:0] tag);
    itlb_miss_v = iv; dtlb_miss_v = dv; itlb_miss_vtag = tag; dtlb_miss_vtag = tag;
    mid();
    tick();
    itlb_miss_v = 0; dtlb_miss_v = 0; ptw_req_ready = 1;
    mid();
    tick();
    ptw_req_ready = 0; flush = 1;
    mid();
    check("flush_wait_busy", busy, 1);
    tick();
    mid();                         // DRAIN, flush still high: no further effect
    check("drain_busy_a", busy, 1);
    check_quiet("drain_a");
    tick();
    flush = 0;
    mid();
    check("drain_busy_b", busy, 1);
    tick();
    ptw_resp_v = 1; ptw_resp_fault = 0;
    mid();
    check("drain_resp_busy", busy, 1);
    check_quiet("drain_resp");
    tick();
    ptw_resp_v = 0;
    mid();
    check("drain_done_busy", busy, 0);
    check_quiet("drain_done");
    tick();
  endtask

  // Transaction-level reference model state for the randomized run.
  bit            m_walk, m_issued, m_result, m_drain, m_prefer_i, m_owner, m_fault;
  logic [VW-1:0] m_tag, m_fill_tag;
  logic [EW-1:0] m_fill_entry;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 27'h1,       27'h2,       1'b0, 1'b0, 40'h11_1111_1111, 2};
    vecs[1] = '{1'b1, 1'b1, 27'h1,       27'h2,       1'b1, 1'b0, 40'h22_2222_2222, 2};
    vecs[2] = '{1'b0, 1'b1, 27'h0,       27'h5,       1'b1, 1'b1, 40'hde_ad00_0005, 0};
    vecs[3] = '{1'b1, 1'b1, 27'h7ff_ffff, 27'h123,    1'b0, 1'b0, 40'hff_ffff_ffff, 0};
    vecs[4] = '{1'b1, 1'b0, 27'h3,       27'h0,       1'b0, 1'b1, 40'h00_0000_0000, 1};
    vecs[5] = '{1'b1, 1'b1, 27'h10,      27'h20,      1'b1, 1'b0, 40'h12_3456_789a, 3};
    vecs[6] = '{1'b0, 1'b1, 27'h0,       27'h555_5555, 1'b1, 1'b0, 40'h55_aa55_aa55, 1};
    vecs[7] = '{1'b1, 1'b1, 27'h2aa_aaaa, 27'h31,     1'b0, 1'b0, 40'h0f_0f0f_0f0f, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), 0);
    @(negedge clk);
    reset_n = 1;
    tick();

    foreach (vecs[i]) run_walk(vecs[i]);

    // Flush in IDLE blocks grants
    itlb_miss_v = 1; itlb_miss_vtag = 27'h44; flush = 1;
    mid();
    check("idle_flush_ready", itlb_miss_ready, 0);
    tick();
    itlb_miss_v = 0; flush = 0;
    mid();
    check("idle_flush_busy", busy, 0);
    tick();

    // Flush in REQ drops the request
    itlb_miss_v = 1; itlb_miss_vtag = 27'h45;
    mid();
    tick();
    itlb_miss_v = 0; flush = 1; ptw_req_ready = 1;
    mid();
    check("req_flush_v", ptw_req_v, 0);
    tick();
    flush = 0; ptw_req_ready = 0;
    mid();
    check("req_flush_busy", busy, 0);
    tick();

    // Backpressure: last grant was ITLB, so DTLB wins and holds for 10 cycles
    itlb_miss_v = 1; dtlb_miss_v = 1; itlb_miss_vtag = 27'h1111; dtlb_miss_vtag = 27'h0abcde;
    mid();
    check("bp_grant_dtlb", dtlb_miss_ready, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      mid();
      check("bp_req_v", ptw_req_v, 1);
      check("bp_req_vtag", ptw_req_vtag, 27'h0abcde);
      check("bp_itlb_ready", itlb_miss_ready, 0);
      check("bp_dtlb_ready", dtlb_miss_ready, 0);
      tick();
    end
    itlb_miss_v = 0; dtlb_miss_v = 0; ptw_req_ready = 1;
    mid();
    tick();
    // Response and flush together in WAIT: flush wins, straight to IDLE
    ptw_req_ready = 0; flush = 1; ptw_resp_v = 1;
    mid();
    check_quiet("flush_resp");
    tick();
    flush = 0; ptw_resp_v = 0;
    mid();
    check("flush_resp_busy", busy, 0);
    check_quiet("flush_resp_after");
    tick();

    flush_wait_walk(1'b1, 1'b0, 27'h42);

    // Flush in FILL suppresses strobes but the payload is still registered
    itlb_miss_v = 1; itlb_miss_vtag = 27'h77;
    mid();
    tick();
    itlb_miss_v = 0; ptw_req_ready = 1;
    mid();
    tick();
    ptw_req_ready = 0; ptw_resp_v = 1; ptw_resp_entry = 40'hab_cdef_0123;
    mid();
    tick();
    ptw_resp_v = 0; flush = 1;
    mid();
    check_quiet("fill_flush");
    check("fill_flush_vtag", fill_vtag, 27'h77);
    tick();
    flush = 0;
    mid();
    check("fill_flush_busy", busy, 0);
    tick();

    // Response in IDLE is ignored
    ptw_resp_v = 1;
    mid();
    tick();
    ptw_resp_v = 0;
    mid();
    check_quiet("idle_resp");
    check("idle_resp_busy", busy, 0);
    tick();

    // Asynchronous reset in WAIT
    dtlb_miss_v = 1; dtlb_miss_vtag = 27'h99;
    mid();
    tick();
    dtlb_miss_v = 0; ptw_req_ready = 1;
    mid();
    tick();
    ptw_req_ready = 0; itlb_miss_v = 1; dtlb_miss_v = 1;
    #2;
    reset_n = 0;
    #1;
    check("async_reset_outputs", outs(), 0);
    itlb_miss_v = 0; dtlb_miss_v = 0;
    @(negedge clk);
    reset_n = 1;
    tick();
    ptw_resp_v = 1;
    mid();
    tick();
    ptw_resp_v = 0;
    mid();
    check_quiet("after_reset_resp");
    check("after_reset_busy", busy, 0);
    tick();

`ifdef BP_TLB_PTW_ARB_PERF_EN
    do_reset();
    for (int i = 0; i < 3; i++) run_walk('{1'b1, 1'b0, VW'(i + 8), 27'h0, 1'b0, 1'b0, 40'h1, 0});
    run_walk('{1'b0, 1'b1, 27'h0, 27'h66, 1'b1, 1'b0, 40'h2, 1});
    flush_wait_walk(1'b0, 1'b1, 27'h67);
    check("perf_itlb_grants", itlb_grants, 3);
    check("perf_dtlb_grants", dtlb_grants, 2);
    check("perf_flush_aborts", flush_aborts, 1);
`endif

    // Randomized run against the transaction-level model
    do_reset();
    m_walk = 0; m_issued = 0; m_result = 0; m_drain = 0; m_prefer_i = 1;
    m_owner = 0; m_fault = 0; m_tag = '0; m_fill_tag = '0; m_fill_entry = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic          idle, gi, gd, strobe, exp_req;
      logic [127:0]  exp;
      itlb_miss_v    = ($urandom_range(0, 1) == 1);
      dtlb_miss_v    = ($urandom_range(0, 1) == 1);
      itlb_miss_vtag = VW'($urandom);
      dtlb_miss_vtag = VW'($urandom);
      ptw_req_ready  = ($urandom_range(0, 1) == 1);
      ptw_resp_v     = ($urandom_range(0, 3) == 0);
      ptw_resp_fault = ($urandom_range(0, 2) == 0);
      ptw_resp_entry = {8'($urandom), 32'($urandom)};
      flush          = ($urandom_range(0, 19) == 0);
      mid();
      idle    = !(m_walk || m_result || m_drain);
      gi      = idle && !flush && itlb_miss_v && (!dtlb_miss_v || m_prefer_i);
      gd      = idle && !flush && dtlb_miss_v && !gi;
      exp_req = m_walk && !m_issued && !flush;
      strobe  = m_result && !flush;
      exp = {gi, gd, exp_req, m_tag, strobe && !m_fault && !m_owner, strobe && !m_fault && m_owner,
             m_fill_tag, m_fill_entry, strobe && m_fault, strobe && m_fault && m_owner, !idle};
      check("random_cycle", outs(), exp);
      if (gi || gd) begin
        m_walk = 1; m_issued = 0; m_owner = gd; m_prefer_i = gd;
        m_tag = gd ? dtlb_miss_vtag : itlb_miss_vtag;
      end else if (m_walk && !m_issued) begin
        if (flush) m_walk = 0;
        else if (ptw_req_ready) m_issued = 1;
      end else if (m_walk) begin
        if (flush) begin
          m_walk = 0; m_drain = !ptw_resp_v;
        end else if (ptw_resp_v) begin
          m_walk = 0; m_result = 1; m_fault = ptw_resp_fault;
          m_fill_tag = m_tag; m_fill_entry = ptw_resp_entry;
        end
      end else if (m_result) begin
        m_result = 0;
      end else if (m_drain && ptw_resp_v) begin
        m_drain = 0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_tlb_ptw_arbiter.md
BP_TLB_PTW_ARBITER -- requirements
Module: bp_tlb_ptw_arbiter

Interface
REQ-001 The block SHALL take these parameters: vtag_width_p, 27, virtual tag width; entry_width_p, 40, TLB leaf entry width.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk_i  in  1  sole clock, rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- itlb_miss_v_i  in  1  ITLB miss request valid.
- itlb_miss_vtag_i  in  vtag_width_p  ITLB miss tag.
- itlb_miss_ready_o  out  1  ITLB request accepted when high with valid.
- dtlb_miss_v_i  in  1  DTLB miss request valid.
- dtlb_miss_vtag_i  in  vtag_width_p  DTLB miss tag.
- dtlb_miss_ready_o  out  1  DTLB request accepted when high with valid.
- ptw_req_v_o  out  1  walk request valid.
- ptw_req_vtag_o  out  vtag_width_p  walk tag.
- ptw_req_ready_i  in  1  walker accepts request.
- ptw_resp_v_i  in  1  walk response valid, one-cycle pulse.
- ptw_resp_fault_i  in  1  walk faulted.
- ptw_resp_entry_i  in  entry_width_p  leaf entry.
- itlb_fill_v_o / dtlb_fill_v_o  out  1  one-cycle fill strobe per TLB.
- fill_vtag_o  out  vtag_width_p  fill tag, shared.
- fill_entry_o  out  entry_width_p  fill entry, shared.
- fault_v_o  out  1  one-cycle fault strobe.
- fault_src_o  out  1  fault owner: 0 = ITLB, 1 = DTLB.
- flush_i  in  1  sfence / TLB clear; aborts the in-flight walk.
- busy_o  out  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have five states, IDLE, REQ, WAIT, FILL and DRAIN, and SHALL hold exactly one walk in flight.
REQ-004 In IDLE without flush_i, the block SHALL grant a single requester combinationally and raise only that requester's ready.
- If only one requester is valid, that requester is granted.
- If both are valid, the block grants the requester opposite last_grant_r.
REQ-005 On a v&ready handshake, the block SHALL capture the tag and the owner, set last_grant_r to the owner, and go to REQ.
REQ-006 In REQ, ptw_req_v_o SHALL be 1 with the captured tag, and the block SHALL go to WAIT on ptw_req_ready_i.
REQ-007 In WAIT, on ptw_resp_v_i the block SHALL register the entry, the tag and the fault bit, then go to FILL.
REQ-008 In FILL, the block SHALL assert the strobe for the result for one cycle, then return to IDLE.
- No fault: the owner's fill_v strobe is asserted.
- Fault: fault_v_o is asserted with fault_src_o = owner.
- The first new grant is possible in the cycle after FILL, giving a 3-cycle minimum from accept to strobe.
REQ-009 flush_i SHALL take effect as follows.
- In IDLE it SHALL block grants.
- In REQ it SHALL drop the request and go to IDLE.
- In WAIT it SHALL go to DRAIN.
- In FILL it SHALL suppress both fill and fault strobes.
REQ-010 DRAIN SHALL discard the next ptw_resp_v_i and then go to IDLE; flush_i in DRAIN SHALL have no further effect.
REQ-011 A ptw_resp_v_i outside WAIT/DRAIN SHALL be ignored.
REQ-012 If ptw_resp_v_i and flush_i arrive in the same WAIT cycle, flush SHALL win: the block goes to IDLE with no strobe.
REQ-013 fill_vtag_o and fill_entry_o SHALL hold their last registered values outside FILL.

Reset
REQ-014 Reset SHALL put the FSM in IDLE and clear all outputs to 0.
REQ-015 Reset SHALL set last_grant_r to 1, so ITLB wins the first tie.
REQ-016 Reset asserted mid-walk SHALL abandon the walk with no strobe.

Configuration
REQ-017 With BP_TLB_PTW_ARB_PERF_EN defined, the block SHALL have these 32-bit saturating counters:
- itlb_grants_o and dtlb_grants_o, incremented on each grant;
- flush_aborts_o, incremented on each entry to DRAIN or REQ abort.
Reset SHALL clear the counters.
REQ-018 Without BP_TLB_PTW_ARB_PERF_EN, those ports and counters SHALL be absent, and behaviour SHALL be otherwise identical.

Verification
REQ-019 The bench SHALL cover these directed scenarios.
- Tie: both miss_v high from reset, ITLB tag 0x1, DTLB tag 0x2, with ptw_req_ready_i=1 and a response 2 cycles later -> ITLB is served first, then DTLB; itlb_fill_v_o and dtlb_fill_v_o pulse in that order.
- Fault: DTLB tag 0x5, response with fault=1 -> fault_v_o=1 for one cycle, fault_src_o=1, dtlb_fill_v_o never high.
- Flush in WAIT: flush_i in WAIT, response 3 cycles later -> DRAIN, no strobe, busy_o drops the cycle after the response.
- Backpressure: ptw_req_ready_i low for 10 cycles -> ptw_req_v_o stays high with a stable tag, and neither miss ready rises.
- Async reset in WAIT -> all outputs are 0 immediately, and a subsequent response produces no strobe.
- PERF_EN: 3 ITLB walks, 2 DTLB walks and 1 flush abort -> counters read 3/2/1.
